// File: rtl/dac_start_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dac_start_pkg
// Brief    : Shared state encoding, parameter defaults and helpers for the
//            DAC start sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package dac_start_pkg;

    localparam int unsigned C_NUM_CH_DEF  = 4;
    localparam int unsigned C_CNT_W_DEF   = 16;
    localparam int unsigned C_PULSE_W_DEF = 1;
    localparam int unsigned C_GAP_W_DEF   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_e;

    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic seq_busy(input seq_state_e s);
        return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_GAP);
    endfunction

endpackage : dac_start_pkg
`default_nettype wire

// File: rtl/dac_trigger_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dac_trigger_edge
// Brief    : Registers the trigger and flags its rising edge for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dac_trigger_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_det
);

    logic trigger_q;
    logic trigger_d;

    always_comb begin
        trigger_d = i_trigger;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= trigger_d;
        end
    end

    // A held-high trigger produces a single detection.
    assign o_det = i_trigger & ~trigger_q;

endmodule : dac_trigger_edge
`default_nettype wire

// File: rtl/dac_start_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dac_start_sequencer
// Brief    : Issues delayed, one-hot start pulses to NUM_CH DACs per trigger.
// Revision : 1.0 - initial release
// ============================================================================
module dac_start_sequencer
    import dac_start_pkg::*;
#(
    parameter int unsigned NUM_CH  = C_NUM_CH_DEF,
    parameter int unsigned CNT_W   = C_CNT_W_DEF,
    parameter int unsigned PULSE_W = C_PULSE_W_DEF,
    parameter int unsigned GAP_W   = C_GAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              trigger,
    input  logic [CNT_W-1:0]  delay,
    output logic [NUM_CH-1:0] dac_start,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned             C_CH_W     = ch_idx_w(NUM_CH);
    localparam logic [CNT_W-1:0]        C_PULSE_LD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0]        C_GAP_LD   = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0]        C_CNT_ONE  = CNT_W'(1);
    localparam logic [C_CH_W-1:0]       C_LAST_CH  = C_CH_W'(NUM_CH - 1);
    localparam logic [C_CH_W-1:0]       C_CH_ONE   = C_CH_W'(1);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [C_CH_W-1:0]   ch_q;
    logic [C_CH_W-1:0]   ch_d;
    logic                done_q;
    logic                done_d;
    logic                rearm_block_q;
    logic                rearm_block_d;

    logic                w_det;
    logic                w_cnt_last;
    logic [CNT_W-1:0]    w_cnt_dec;

    dac_trigger_edge u_trigger_edge (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (trigger),
        .o_det     (w_det)
    );

    // Counters saturate at zero so a bad load can never wrap around.
    assign w_cnt_last = (cnt_q <= C_CNT_ONE);
    assign w_cnt_dec  = (cnt_q == '0) ? '0 : (cnt_q - C_CNT_ONE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_d          = ch_q;
        done_d        = 1'b0;
        rearm_block_d = rearm_block_q;

        if (!start) begin
            rearm_block_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !rearm_block_q) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // A trigger landing on the done cycle must not restart.
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (w_det && !done_q) begin
                    ch_d = '0;
                    if (delay == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = C_PULSE_LD;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = delay;
                    end
                end
            end

            ST_DELAY: begin
                if (w_cnt_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = C_PULSE_LD;
                end else begin
                    cnt_d = w_cnt_dec;
                end
            end

            ST_PULSE: begin
                if (!w_cnt_last) begin
                    cnt_d = w_cnt_dec;
                end else if (ch_q == C_LAST_CH) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (mode && start) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d       = ST_IDLE;
                        rearm_block_d = start;
                    end
                end else if (GAP_W == 0) begin
                    ch_d  = ch_q + C_CH_ONE;
                    cnt_d = C_PULSE_LD;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = C_GAP_LD;
                end
            end

            ST_GAP: begin
                if (w_cnt_last) begin
                    state_d = ST_PULSE;
                    ch_d    = ch_q + C_CH_ONE;
                    cnt_d   = C_PULSE_LD;
                end else begin
                    cnt_d = w_cnt_dec;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ch_q          <= '0;
            done_q        <= 1'b0;
            rearm_block_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ch_q          <= ch_d;
            done_q        <= done_d;
            rearm_block_q <= rearm_block_d;
        end
    end

    // Outputs decode the state directly so reset clears them without a clock.
    generate
        for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_dac_start
            assign dac_start[i] = (state_q == ST_PULSE) && (ch_q == C_CH_W'(i));
        end
    endgenerate

    assign busy    = seq_busy(state_q);
    assign done    = done_q;
    assign overrun = w_det & (busy | done_q);

endmodule : dac_start_sequencer
`default_nettype wire

// File: tb/tb_dac_start_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dac_start_sequencer
// Brief    : Scoreboard bench: expected output events queued by stimulus,
//            matched by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_start_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic        trigger;
    logic [15:0] delay;
    logic [3:0]  dac_start;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n;

    typedef struct {
        int         cyc;
        logic [3:0] dac;
        logic       done;
        logic       ovr;
    } ev_t;

    ev_t exp_q[$];

    dac_start_sequencer #(
        .NUM_CH  (4),
        .CNT_W   (16),
        .PULSE_W (2),
        .GAP_W   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .trigger   (trigger),
        .delay     (delay),
        .dac_start (dac_start),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] d, input logic dn, input logic ov);
        ev_t e;
        e.cyc  = c;
        e.dac  = d;
        e.done = dn;
        e.ovr  = ov;
        exp_q.push_back(e);
    endtask

    // Four 2-cycle pulses spaced by 1 idle cycle, then done.
    task automatic push_seq(input int base, input int d, input logic ovr_at_done);
        for (int ch = 0; ch < 4; ch++) begin
            logic [3:0] v;
            int s;
            v = 4'b0001 << ch;
            s = base + d + 1 + ch * 3;
            push_ev(s, v, 1'b0, 1'b0);
            push_ev(s + 1, v, 1'b0, 1'b0);
        end
        push_ev(base + d + 12, 4'b0000, 1'b1, ovr_at_done);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (dac_start != 4'b0000 || done || overrun) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d dac=%b done=%b ovr=%b, none expected",
                             cyc, dac_start, done, overrun);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.dac !== dac_start || e.done !== done || e.ovr !== overrun) begin
                        n_fail++;
                        $display("FAIL event: got cycle %0d dac=%b done=%b ovr=%b, expected cycle %0d dac=%b done=%b ovr=%b",
                                 cyc, dac_start, done, overrun, e.cyc, e.dac, e.done, e.ovr);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        reset   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        trigger = 1'b0;
        delay   = 16'd0;
        tick(3);
        chk("reset_dac_start", 32'(dac_start), 32'h0);
        chk("reset_busy",      32'(busy),      32'h0);
        chk("reset_done",      32'(done),      32'h0);
        chk("reset_overrun",   32'(overrun),   32'h0);
        reset = 1'b1;
        tick(2);

        // Single-shot, delay 3
        start = 1'b1;
        delay = 16'd3;
        tick(2);
        trigger = 1'b1;
        n = cyc;
        push_seq(n, 3, 1'b0);
        tick(1);
        trigger = 1'b0;
        chk("busy_in_delay", 32'(busy), 32'h1);
        tick(20);
        chk("busy_after_seq", 32'(busy), 32'h0);

        // Single-shot needs start low then high before re-arming
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(20);

        // Delay 0
        start = 1'b0;
        tick(2);
        start = 1'b1;
        delay = 16'd0;
        tick(2);
        trigger = 1'b1;
        n = cyc;
        push_seq(n, 0, 1'b0);
        tick(1);
        trigger = 1'b0;
        tick(20);

        // Delay 20 with a second trigger during the delay
        start = 1'b0;
        tick(2);
        start = 1'b1;
        delay = 16'd20;
        tick(2);
        trigger = 1'b1;
        n = cyc;
        push_ev(n + 10, 4'b0000, 1'b0, 1'b1);
        push_seq(n, 20, 1'b0);
        tick(1);
        trigger = 1'b0;
        tick(9);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(40);

        // Continuous mode, one trigger every 100 cycles
        start = 1'b0;
        mode  = 1'b1;
        tick(2);
        start = 1'b1;
        delay = 16'd3;
        tick(2);
        for (int p = 0; p < 5; p++) begin
            trigger = 1'b1;
            n = cyc;
            push_seq(n, 3, 1'b0);
            tick(1);
            trigger = 1'b0;
            tick(99);
        end

        // Trigger on the done cycle: overrun, no restart
        trigger = 1'b1;
        n = cyc;
        push_seq(n, 3, 1'b1);
        tick(1);
        trigger = 1'b0;
        tick(14);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(20);
        chk("busy_no_restart", 32'(busy), 32'h0);

        // start dropped mid-sequence: sequence completes, then idle
        mode    = 1'b0;
        trigger = 1'b1;
        n = cyc;
        push_seq(n, 3, 1'b0);
        tick(1);
        trigger = 1'b0;
        tick(5);
        start = 1'b0;
        chk("busy_after_start_drop", 32'(busy), 32'h1);
        tick(20);
        chk("busy_idle_after_drop", 32'(busy), 32'h0);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(20);

        // Reset during the channel-0 pulse
        start = 1'b1;
        delay = 16'd3;
        tick(2);
        trigger = 1'b1;
        n = cyc;
        push_ev(n + 4, 4'b0001, 1'b0, 1'b0);
        tick(1);
        trigger = 1'b0;
        tick(4);
        chk("dac_before_reset", 32'(dac_start), 32'h1);
        reset   = 1'b0;
        trigger = 1'b1;
        #1;
        chk("reset_mid_pulse_dac",  32'(dac_start), 32'h0);
        chk("reset_mid_pulse_busy", 32'(busy),      32'h0);
        tick(3);
        reset = 1'b1;
        tick(30);
        chk("held_trigger_busy", 32'(busy), 32'h0);
        trigger = 1'b0;
        tick(2);
        trigger = 1'b1;
        n = cyc;
        push_seq(n, 3, 1'b0);
        tick(1);
        trigger = 1'b0;
        tick(20);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dac_start_sequencer
`default_nettype wire

// File: doc/dac_start_sequencer.md
DAC_START_SEQUENCER -- requirements
Module: dac_start_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of DAC start channels (1..16).
REQ-002 Parameter CNT_W, default 16: width of the delay input and internal counters.
REQ-003 Parameter PULSE_W, default 1: dac_start pulse width in clk cycles (>=1).
REQ-004 Parameter GAP_W, default 0: idle cycles between consecutive channel pulses (>=0).
REQ-005 Port clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-006 Port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-007 Port start  input  1  enable; level-sensitive arm.
REQ-008 Port mode  input  1  0 = single-shot, 1 = continuous.
REQ-009 Port trigger  input  1  frame/reset strobe, synchronous to clk; its rising edge starts a sequence.
REQ-010 Port delay  input  CNT_W  cycles between trigger edge detection and first pulse; sampled at detection.
REQ-011 Port dac_start  output  NUM_CH  one-hot start pulses, bit i for channel i.
REQ-012 Port busy  output  1  high from detection until the last pulse/gap completes.
REQ-013 Port done  output  1  one-cycle pulse after the final channel's pulse ends.
REQ-014 Port overrun  output  1  one-cycle pulse when a trigger edge is detected while busy.

Function
REQ-015 Trigger edge SHALL be detected as trigger=1 with registered trigger_q=0; detection edge called E.
REQ-016 FSM states SHALL be IDLE, ARMED, DELAY, PULSE, GAP.
REQ-017 IDLE -> ARMED when start=1; ARMED -> IDLE when start=0.
REQ-018 ARMED + detection at E -> DELAY with counter loaded from delay; if delay=0, go directly to PULSE.
REQ-019 dac_start[0] SHALL be high at clock edge E+delay+1 and remain high for exactly PULSE_W cycles.
REQ-020 After channel i pulse: GAP for GAP_W cycles (skipped when GAP_W=0), then PULSE for channel i+1.
REQ-021 At most one dac_start bit SHALL be high in any cycle.
REQ-022 After channel NUM_CH-1: done=1 for one cycle; mode=1 and start=1 -> ARMED; otherwise -> IDLE.
REQ-023 Single-shot: after done, return to ARMED only after start is sampled 0 then 1.
REQ-024 start deasserted mid-sequence SHALL NOT abort; sequence completes, then IDLE.
REQ-025 Trigger edge while in DELAY/PULSE/GAP SHALL be ignored for sequencing and SHALL pulse overrun.
REQ-026 Trigger edge in the same cycle as done SHALL be ignored and SHALL raise overrun; no back-to-back restart.
REQ-027 Trigger held high SHALL produce only one detection.
REQ-028 Counters SHALL be CNT_W bits, count down, and never wrap; delay = 2^CNT_W-1 is legal.
REQ-029 busy SHALL be 1 in DELAY, PULSE and GAP, and 0 otherwise.

Reset
REQ-030 reset=0 SHALL force IDLE, dac_start=0, busy=0, done=0, overrun=0, trigger_q=0, counters=0 asynchronously.
REQ-031 Reset asserted mid-pulse SHALL drop dac_start in the same cycle without completing the pulse.
REQ-032 After release, the first detection requires a fresh 0->1 trigger edge with start=1.

Structure
REQ-033 Shared package dac_start_pkg SHALL hold the FSM state enumeration and parameter defaults.
REQ-034 One sub-module, dac_trigger_edge, SHALL hold trigger_q and produce the one-cycle detection strobe.
REQ-035 Channel index SHALL use $clog2(NUM_CH) bits (min 1).

Verification (NUM_CH=4, PULSE_W=2, GAP_W=1, clk 1 MHz)
REQ-036 start=1, mode=0, delay=3, trigger at E -> dac_start = 0001 at E+4..E+5, 0010 at E+7..E+8, 0100 at E+10..E+11, 1000 at E+13..E+14; done at E+15.
REQ-037 mode=1, start=1, trigger every 100 cycles for 5 periods -> 5 complete sequences and 5 done pulses, overrun never asserted.
REQ-038 delay=0 -> dac_start[0] high at E+1; delay=20, second trigger at E+10 -> overrun at E+10, single sequence only.
REQ-039 start dropped at E+6 during a sequence -> all 4 pulses still issued, then IDLE; later trigger -> no pulses.
REQ-040 reset asserted at E+5 during a channel-0 pulse -> all outputs 0 immediately; after release, trigger held high -> no pulses until a new edge arrives.
